// File: rtl/cf_wb_irq_regs.sv
// Wishbone register/interrupt front-end: core-page pass-through plus IM/MIS/RIS/ICR/GCLK on page 0xFF.
// Optional flag synchronizer: define CF_WB_IRQ_SYNC_EN.
module cf_wb_irq_regs #(
    parameter int                   NUM_FLAGS = 9,
    parameter logic [NUM_FLAGS-1:0] EDGE_MASK = {NUM_FLAGS{1'b1}}
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [15:0]          adr_i,
    input  logic [31:0]          dat_i,
    output logic [31:0]          dat_o,
    input  logic [3:0]           sel_i,
    input  logic                 cyc_i,
    input  logic                 stb_i,
    input  logic                 we_i,
    output logic                 ack_o,
    output logic                 core_stb_o,
    input  logic [31:0]          core_dat_i,
    input  logic                 core_ack_i,
    input  logic [NUM_FLAGS-1:0] flags_i,
    output logic                 clk_en_o,
    output logic                 irq_o
);
    localparam logic [7:0] ADR_IM   = 8'h00;
    localparam logic [7:0] ADR_MIS  = 8'h04;
    localparam logic [7:0] ADR_RIS  = 8'h08;
    localparam logic [7:0] ADR_ICR  = 8'h0C;
    localparam logic [7:0] ADR_GCLK = 8'h10;

    logic                 w_local;
    logic                 w_wr;
    logic [NUM_FLAGS-1:0] w_flags;
    logic [NUM_FLAGS-1:0] w_set;
    logic [NUM_FLAGS-1:0] w_clr;
    logic [NUM_FLAGS-1:0] w_ris;
    logic [31:0]          w_im32;
    logic [31:0]          w_ris32;
    logic [31:0]          w_mis32;
    logic [31:0]          w_local_dat;
    logic                 w_unused;

    logic [NUM_FLAGS-1:0] r_im;
    logic [NUM_FLAGS-1:0] r_ris;
    logic [NUM_FLAGS-1:0] r_prev;
    logic                 r_gclk;
    logic                 r_lack;
    logic                 r_irq;

`ifdef CF_WB_IRQ_SYNC_EN
    logic [NUM_FLAGS-1:0] r_sync1;
    logic [NUM_FLAGS-1:0] r_sync2;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= flags_i;
            r_sync2 <= r_sync1;
        end
    end

    assign w_flags = r_sync2;
`else
    assign w_flags = flags_i;
`endif

    assign w_local = (adr_i[15:8] == 8'hFF);
    assign w_wr    = cyc_i & stb_i & we_i & w_local & ~r_lack;

    // Only edge-mode bits are stored; level-mode bits are taken live from the flags.
    assign w_set = w_flags & ~r_prev & EDGE_MASK;
    assign w_clr = (w_wr && adr_i[7:0] == ADR_ICR) ? (dat_i[NUM_FLAGS-1:0] & EDGE_MASK) : '0;
    assign w_ris = r_ris | (w_flags & ~EDGE_MASK);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_im   <= '0;
            r_ris  <= '0;
            r_prev <= '0;
            r_gclk <= 1'b0;
            r_lack <= 1'b0;
            r_irq  <= 1'b0;
        end else begin
            r_lack <= cyc_i & stb_i & w_local & ~r_lack;
            r_prev <= w_flags;
            r_ris  <= (r_ris & ~w_clr) | w_set;
            r_irq  <= |(w_ris & r_im);
            if (w_wr && adr_i[7:0] == ADR_IM) begin
                r_im <= dat_i[NUM_FLAGS-1:0];
            end
            if (w_wr && adr_i[7:0] == ADR_GCLK) begin
                r_gclk <= dat_i[0];
            end
        end
    end

    always_comb begin
        w_im32                   = '0;
        w_ris32                  = '0;
        w_im32[NUM_FLAGS-1:0]    = r_im;
        w_ris32[NUM_FLAGS-1:0]   = w_ris;
        w_mis32                  = w_ris32 & w_im32;
    end

    always_comb begin
        case (adr_i[7:0])
            ADR_IM:   w_local_dat = w_im32;
            ADR_MIS:  w_local_dat = w_mis32;
            ADR_RIS:  w_local_dat = w_ris32;
            ADR_ICR:  w_local_dat = '0;
            ADR_GCLK: w_local_dat = {31'd0, r_gclk};
            default:  w_local_dat = 32'hDEADBEEF;
        endcase
    end

    assign dat_o      = w_local ? w_local_dat : core_dat_i;
    assign ack_o      = w_local ? r_lack : core_ack_i;
    assign core_stb_o = stb_i & ~w_local;
    assign clk_en_o   = r_gclk;
    assign irq_o      = r_irq;

    // Byte selects are ignored and upper write-data bits are unused for local registers.
    assign w_unused = ^{sel_i, dat_i};

endmodule

// File: tb/tb_cf_wb_irq_regs.sv
// Self-checking bench for cf_wb_irq_regs: directed test-plan scenarios plus randomized traffic vs. a reference model.
module tb_cf_wb_irq_regs;
    localparam int            NF   = 9;
    localparam logic [NF-1:0] EDGE = 9'h1DF;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic [15:0]   adr_i;
    logic [31:0]   dat_i;
    logic [31:0]   dat_o;
    logic [3:0]    sel_i;
    logic          cyc_i, stb_i, we_i;
    logic          ack_o;
    logic          core_stb_o;
    logic [31:0]   core_dat_i;
    logic          core_ack_i;
    logic [NF-1:0] flags_i;
    logic          clk_en_o;
    logic          irq_o;

    cf_wb_irq_regs #(.NUM_FLAGS(NF), .EDGE_MASK(EDGE)) u_dut (
        .clk_i(clk_i), .rst_i(rst_i), .adr_i(adr_i), .dat_i(dat_i), .dat_o(dat_o),
        .sel_i(sel_i), .cyc_i(cyc_i), .stb_i(stb_i), .we_i(we_i), .ack_o(ack_o),
        .core_stb_o(core_stb_o), .core_dat_i(core_dat_i), .core_ack_i(core_ack_i),
        .flags_i(flags_i), .clk_en_o(clk_en_o), .irq_o(irq_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [NF-1:0] m_im, m_ris, m_prev;
    logic          m_gclk, m_lack, m_irq;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_im = '0; m_ris = '0; m_prev = '0;
        m_gclk = 1'b0; m_lack = 1'b0; m_irq = 1'b0;
    endtask

    function automatic logic [NF-1:0] ris_eff();
        logic [NF-1:0] r;
        for (int i = 0; i < NF; i++) r[i] = EDGE[i] ? m_ris[i] : flags_i[i];
        return r;
    endfunction

    function automatic logic [31:0] exp_dat();
        logic [31:0] v;
        if (adr_i[15:8] != 8'hFF) return core_dat_i;
        case (adr_i[7:0])
            8'h00:   v = 32'(m_im);
            8'h04:   v = 32'(ris_eff() & m_im);
            8'h08:   v = 32'(ris_eff());
            8'h0C:   v = 32'd0;
            8'h10:   v = {31'd0, m_gclk};
            default: v = 32'hDEADBEEF;
        endcase
        return v;
    endfunction

    task automatic check_all();
        logic loc;
        loc = (adr_i[15:8] == 8'hFF);
        check_eq("ack", ack_o, loc ? m_lack : core_ack_i);
        check_eq("dat", dat_o, exp_dat());
        check_eq("core_stb", core_stb_o, stb_i & ~loc);
        check_eq("irq", irq_o, m_irq);
        check_eq("clk_en", clk_en_o, m_gclk);
    endtask

    // One clock: compute model next state from current inputs, take the edge, then check.
    task automatic step();
        logic          acc, wr;
        logic [NF-1:0] n_ris, n_im;
        logic          n_gclk, n_irq;
        acc    = cyc_i & stb_i & (adr_i[15:8] == 8'hFF) & ~m_lack;
        wr     = acc & we_i;
        n_irq  = |(ris_eff() & m_im);
        n_ris  = m_ris;
        n_im   = m_im;
        n_gclk = m_gclk;
        for (int i = 0; i < NF; i++) begin
            if (EDGE[i]) begin
                if (wr && adr_i == 16'hFF0C && dat_i[i]) n_ris[i] = 1'b0;
                if (flags_i[i] && !m_prev[i])            n_ris[i] = 1'b1;
            end else begin
                n_ris[i] = 1'b0;
            end
        end
        if (wr && adr_i == 16'hFF00) n_im   = dat_i[NF-1:0];
        if (wr && adr_i == 16'hFF10) n_gclk = dat_i[0];
        @(posedge clk_i);
        m_ris = n_ris; m_im = n_im; m_gclk = n_gclk; m_irq = n_irq;
        m_lack = acc; m_prev = flags_i;
        #1;
        check_all();
    endtask

    task automatic wb_read(input logic [15:0] adr, input logic [31:0] exp);
        adr_i = adr; we_i = 1'b0; cyc_i = 1'b1; stb_i = 1'b1;
        #1;
        check_eq("rd_comb", dat_o, exp);
        step();
        check_eq("rd_ack", ack_o, 1);
        check_eq("rd_dat", dat_o, exp);
        cyc_i = 1'b0; stb_i = 1'b0;
        step();
        check_eq("rd_ack_drop", ack_o, 0);
    endtask

    task automatic wb_write(input logic [15:0] adr, input logic [31:0] data);
        adr_i = adr; dat_i = data; we_i = 1'b1; cyc_i = 1'b1; stb_i = 1'b1;
        step();
        check_eq("wr_ack", ack_o, 1);
        cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
        step();
    endtask

    initial begin
        logic [15:0] adrs [9];
        adrs = '{16'hFF00, 16'hFF04, 16'hFF08, 16'hFF0C, 16'hFF10, 16'hFF20, 16'hFF01, 16'h0004, 16'h1234};

        rst_i = 1'b1; adr_i = 16'hFF00; dat_i = '0; sel_i = 4'hF;
        cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
        core_dat_i = '0; core_ack_i = 1'b0; flags_i = '0;
        model_reset();
        #1;
        check_all();
        #11 rst_i = 1'b0;

        // Reset values and unmapped local read
        wb_read(16'hFF00, 32'h0);
        wb_read(16'hFF04, 32'h0);
        wb_read(16'hFF08, 32'h0);
        wb_read(16'hFF10, 32'h0);
        wb_read(16'hFF20, 32'hDEADBEEF);

        // Held strobe acks every other cycle
        adr_i = 16'hFF00; cyc_i = 1'b1; stb_i = 1'b1;
        step(); check_eq("hold_ack1", ack_o, 1);
        step(); check_eq("hold_ack2", ack_o, 0);
        step(); check_eq("hold_ack3", ack_o, 1);
        cyc_i = 1'b0; stb_i = 1'b0;
        step();

        // Edge capture of flag 3, irq latency, W1C
        wb_write(16'hFF00, 32'h1FF);
        flags_i = 9'h008;
        step(); check_eq("irq_lat0", irq_o, 0);
        flags_i = '0;
        step(); check_eq("irq_lat1", irq_o, 1);
        wb_read(16'hFF08, 32'h008);
        wb_read(16'hFF04, 32'h008);
        wb_write(16'hFF0C, 32'h008);
        check_eq("irq_cleared", irq_o, 0);
        wb_read(16'hFF08, 32'h0);
        wb_read(16'hFF0C, 32'h0);

        // Set wins over same-cycle clear
        adr_i = 16'hFF0C; dat_i = 32'h1; we_i = 1'b1; cyc_i = 1'b1; stb_i = 1'b1; flags_i = 9'h001;
        step(); check_eq("setwin_ack", ack_o, 1);
        cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
        step();
        wb_read(16'hFF08, 32'h001);
        wb_write(16'hFF0C, 32'h001);
        wb_read(16'hFF08, 32'h000);
        flags_i = '0;
        step();

        // Level flag 5: live, immune to ICR
        flags_i = 9'h020;
        wb_read(16'hFF08, 32'h020);
        wb_write(16'hFF0C, 32'h020);
        wb_read(16'hFF08, 32'h020);
        adr_i = 16'hFF08; flags_i = '0;
        #1 check_eq("lvl_fall", dat_o, 32'h0);
        step(); step();

        // Core page pass-through with delayed core ack
        adr_i = 16'h0004; we_i = 1'b1; dat_i = 32'h0; cyc_i = 1'b1; stb_i = 1'b1;
        core_dat_i = 32'hA5A55A5A; core_ack_i = 1'b0;
        #1;
        check_eq("core_stb", core_stb_o, 1);
        check_eq("core_ack0", ack_o, 0);
        check_eq("core_dat", dat_o, 32'hA5A55A5A);
        repeat (3) step();
        core_ack_i = 1'b1;
        #1 check_eq("core_ack1", ack_o, 1);
        step();
        cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0; core_ack_i = 1'b0;
        #1 check_eq("core_stb_off", core_stb_o, 0);
        step();
        wb_read(16'hFF00, 32'h1FF);

        // GCLK and asynchronous reset mid-access
        wb_write(16'hFF10, 32'h1);
        check_eq("clk_en_on", clk_en_o, 1);
        flags_i = 9'h002;
        step();
        flags_i = '0;
        step(); check_eq("irq_pre_rst", irq_o, 1);
        adr_i = 16'hFF08; cyc_i = 1'b1; stb_i = 1'b1;
        step(); check_eq("ack_pre_rst", ack_o, 1);
        #2 rst_i = 1'b1;
        #1;
        check_eq("rst_ack", ack_o, 0);
        check_eq("rst_clk_en", clk_en_o, 0);
        check_eq("rst_irq", irq_o, 0);
        model_reset();
        cyc_i = 1'b0; stb_i = 1'b0;
        #3 rst_i = 1'b0;
        wb_read(16'hFF00, 32'h0);

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            adr_i      = adrs[$urandom_range(0, 8)];
            we_i       = 1'($urandom_range(0, 1));
            cyc_i      = ($urandom_range(0, 3) != 0);
            stb_i      = ($urandom_range(0, 3) != 0);
            dat_i      = $urandom;
            core_dat_i = $urandom;
            core_ack_i = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 2) == 0) flags_i[$urandom_range(0, NF-1)] ^= 1'b1;
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
